spi_burst_arbiter: RTL and testbench
====================================

SPI_BURST_ARBITER -- requirements
Module: spi_burst_arbiter

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 1023, meaning the maximum clk cycles to wait for TRDY or RRDY before aborting a burst.
REQ-002 SHALL have port clk  in  1  system clock (50 MHz).
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  in  2  per-requester burst request, held until that requester's done.
REQ-005 SHALL have port req_len  in  8  two 4-bit byte counts, [3:0] for requester 0 and [7:4] for requester 1; 0 means 16.
REQ-006 SHALL have port tx_byte  in  16  two 8-bit next-TX bytes, [7:0] for requester 0 and [15:8] for requester 1.
REQ-007 SHALL have the following requester-side outputs:
- grant  out  2  one-hot owner.
- tx_pop  out  2  1-cycle "byte consumed" pulse.
- rx_byte  out  8  received byte.
- rx_valid  out  2  1-cycle "rx_byte valid" pulse.
- done  out  2  1-cycle end-of-burst pulse.
- err  out  1  timeout flag, valid with done.
REQ-008 SHALL have the following SPI-core master ports:
- spi_addr  out  3
- spi_wdata  out  16
- spi_select  out  1
- spi_read_n  out  1
- spi_write_n  out  1
- spi_rdata  in  16
- spi_trdy  in  1  readyfordata.
- spi_rrdy  in  1  dataavailable.

Function
REQ-009 SHALL perform every core access as exactly 2 clk cycles, with spi_select=1 and the strobe low, then 1 idle cycle with spi_select=0 and both strobes high.
REQ-010 SHALL sample spi_rdata at the clock edge ending the second cycle of a read access.
REQ-011 SHALL, in IDLE with any req bit set, register grant on the next edge.
- Single request: that requester is granted.
- Both requesting: the requester not served last is granted.
- After reset, requester 0 has priority.
REQ-012 SHALL latch the granted req_len into a 5-bit remaining counter at grant, mapping 0 to 16.
REQ-013 SHALL sequence states IDLE -> SSO_ON -> WAIT_TRDY -> WR_DATA -> WAIT_RRDY -> RD_DATA -> (WAIT_TRDY if remaining>0, else SSO_OFF) -> DONE -> IDLE.
REQ-014 SSO_ON SHALL write addr 3 with data 0x0400, which holds SS_n low across bytes with interrupts disabled.
REQ-015 WR_DATA SHALL write addr 1 with {8'h00, granted tx_byte} and pulse tx_pop[owner] in the second access cycle.
REQ-016 WAIT_TRDY and WAIT_RRDY SHALL advance only when spi_trdy or spi_rrdy respectively is 1.
REQ-017 RD_DATA SHALL read addr 0 and present rx_byte = spi_rdata[7:0] with a 1-cycle rx_valid[owner] the cycle after sampling, then decrement remaining.
REQ-018 SSO_OFF SHALL write addr 3 with 0x0000.
REQ-019 DONE SHALL pulse done[owner] for 1 cycle, clear grant, and update the last-served pointer.
REQ-020 A new grant SHALL NOT be issued earlier than the cycle after DONE.
REQ-021 SHALL keep a 10-bit wait counter that is cleared on entry to WAIT_TRDY or WAIT_RRDY.
REQ-022 On the wait counter reaching WAIT_LIMIT, SHALL abort to SSO_OFF, set err=1 through DONE, and issue no further tx_pop or rx_valid.
REQ-023 Deassertion of req by the owner mid-burst SHALL be ignored; the burst completes.
REQ-024 SHALL never assert spi_read_n and spi_write_n low in the same cycle.

Reset
REQ-025 Asserting reset_n=0 SHALL asynchronously force:
- state IDLE;
- grant, tx_pop, rx_valid, done, err = 0;
- rx_byte = 0, spi_addr = 0, spi_wdata = 0;
- spi_select = 0, spi_read_n = 1, spi_write_n = 1;
- remaining counter, wait counter and last-served pointer (requester 1) = 0/1 as listed.
REQ-026 Reset mid-burst SHALL abandon the burst without emitting done; an SSO release is not owed because the core shares reset_n.

Structure
REQ-027 A shared package SHALL hold the state enum and the core register address constants: RXDATA=0, TXDATA=1, STATUS=2, CONTROL=3, SLAVESEL=5, EOPVAL=6.
REQ-028 The package SHALL also hold the control constants CTRL_SSO=16'h0400 and CTRL_IDLE=16'h0000.
REQ-029 The 2-cycle access plus idle-gap sequencing SHALL be one sub-module, spi_bus_access, with start/busy/done and rdata capture.

Verification
REQ-030 Single burst: req=01, len=3, tx bytes A1,B2,C3, MISO echo model returns the same bytes -> the bench SHALL check:
- write addr3=0x0400;
- three addr1 writes, three tx_pop[0] pulses and three rx_valid[0] pulses with rx_byte A1,B2,C3;
- write addr3=0x0000;
- done[0] with err=0.
REQ-031 Contention: req=11 from reset -> the bench SHALL check grant order 01,10,01 across three successive bursts.
REQ-032 len=0: req=10, req_len[7:4]=0 -> the bench SHALL check exactly 16 tx_pop[1] pulses and 16 rx_valid[1] pulses before done[1].
REQ-033 Timeout: spi_rrdy stuck 0, WAIT_LIMIT=15 -> the bench SHALL check abort after 15 wait cycles, write addr3=0x0000, and done with err=1.
REQ-034 Reset mid-burst after byte 1 -> the bench SHALL check all outputs return to their reset values immediately, with no done, and a fresh burst succeeds afterwards.
REQ-035 Protocol check throughout: the bench SHALL confirm every access is 2 strobe cycles plus 1 gap, and that read and write strobes are never both active.

Source files
------------

// File: rtl/spi_burst_arbiter_pkg.sv
// Shared types and SPI-core register map for the two-requester SPI burst arbiter.
// Holds the FSM encodings, core register addresses and control-word constants.
package spi_burst_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SSO_ON,
      ST_WAIT_TRDY,
      ST_WR_DATA,
      ST_WAIT_RRDY,
      ST_RD_DATA,
      ST_SSO_OFF,
      ST_DONE
   } arb_state_t;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_STB1,
      PH_STB2,
      PH_GAP
   } bus_phase_t;

   localparam logic [2:0] ADDR_RXDATA   = 3'd0;
   localparam logic [2:0] ADDR_TXDATA   = 3'd1;
   localparam logic [2:0] ADDR_STATUS   = 3'd2;
   localparam logic [2:0] ADDR_CONTROL  = 3'd3;
   localparam logic [2:0] ADDR_SLAVESEL = 3'd5;
   localparam logic [2:0] ADDR_EOPVAL   = 3'd6;

   localparam logic [15:0] CTRL_SSO  = 16'h0400;
   localparam logic [15:0] CTRL_IDLE = 16'h0000;

   // A zero nibble encodes a 16-byte burst.
   function automatic logic [4:0] burst_len(input logic [3:0] nib);
      return {(nib == 4'd0), nib};
   endfunction

endpackage

// File: rtl/spi_burst_arbiter_bus.sv
// One SPI-core master access: two strobe cycles with select high, then one idle gap cycle.
// Read data is captured at the edge that ends the second strobe cycle.
module spi_bus_access
   import spi_burst_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_start,
   input  logic        i_read,
   input  logic [2:0]  i_addr,
   input  logic [15:0] i_wdata,
   output logic        o_busy,
   output logic        o_stb2,
   output logic        o_done,
   output logic [7:0]  o_rdata,
   output logic [2:0]  o_spi_addr,
   output logic [15:0] o_spi_wdata,
   output logic        o_spi_select,
   output logic        o_spi_read_n,
   output logic        o_spi_write_n,
   input  logic [7:0]  i_spi_rdata
);

   bus_phase_t  r_phase, w_phase_nxt;
   logic        r_read;
   logic [7:0]  r_rdata;
   logic [2:0]  r_addr;
   logic [15:0] r_wdata;
   logic        r_select, r_read_n, r_write_n;

   always_comb begin
      w_phase_nxt = r_phase;
      case (r_phase)
         PH_IDLE: if (i_start) w_phase_nxt = PH_STB1;
         PH_STB1: w_phase_nxt = PH_STB2;
         PH_STB2: w_phase_nxt = PH_GAP;
         default: w_phase_nxt = PH_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_phase   <= PH_IDLE;
         r_read    <= 1'b0;
         r_rdata   <= 8'h00;
         r_addr    <= 3'd0;
         r_wdata   <= 16'h0000;
         r_select  <= 1'b0;
         r_read_n  <= 1'b1;
         r_write_n <= 1'b1;
      end else begin
         r_phase <= w_phase_nxt;
         if (r_phase == PH_IDLE && i_start) begin
            r_read    <= i_read;
            r_addr    <= i_addr;
            r_wdata   <= i_wdata;
            r_select  <= 1'b1;
            r_read_n  <= ~i_read;
            r_write_n <= i_read;
         end
         // Strobes drop together with select so they never overlap the gap.
         if (r_phase == PH_STB2) begin
            r_select  <= 1'b0;
            r_read_n  <= 1'b1;
            r_write_n <= 1'b1;
            if (r_read) r_rdata <= i_spi_rdata;
         end
      end
   end

   assign o_busy        = (r_phase != PH_IDLE);
   assign o_stb2        = (r_phase == PH_STB2);
   assign o_done        = (r_phase == PH_GAP);
   assign o_rdata       = r_rdata;
   assign o_spi_addr    = r_addr;
   assign o_spi_wdata   = r_wdata;
   assign o_spi_select  = r_select;
   assign o_spi_read_n  = r_read_n;
   assign o_spi_write_n = r_write_n;

endmodule

// File: rtl/spi_burst_arbiter.sv
// Round-robin arbiter that runs byte bursts for two requesters through an SPI-core
// master port, holding slave select across the burst and aborting on TRDY/RRDY timeout.
module spi_burst_arbiter
   import spi_burst_arbiter_pkg::*;
#(
   parameter int WAIT_LIMIT = 1023
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  req,
   input  logic [7:0]  req_len,
   input  logic [15:0] tx_byte,
   output logic [1:0]  grant,
   output logic [1:0]  tx_pop,
   output logic [7:0]  rx_byte,
   output logic [1:0]  rx_valid,
   output logic [1:0]  done,
   output logic        err,
   output logic [2:0]  spi_addr,
   output logic [15:0] spi_wdata,
   output logic        spi_select,
   output logic        spi_read_n,
   output logic        spi_write_n,
   input  logic [15:0] spi_rdata,
   input  logic        spi_trdy,
   input  logic        spi_rrdy
);

   arb_state_t  r_state, w_state_nxt;
   logic [1:0]  r_grant;
   logic [4:0]  r_remaining;
   logic [9:0]  r_wait;
   logic        r_err, r_last;
   logic        w_pick1, w_in_wait, w_wait_hit, w_abort;
   logic        w_start, w_read, w_bus_busy, w_bus_stb2, w_bus_done;
   logic [2:0]  w_addr;
   logic [15:0] w_wdata;
   logic [7:0]  w_tx;
   logic [7:0]  w_rdata;

   // With both requesting, the one not served last wins; r_last resets to 1.
   assign w_pick1    = req[1] & (~req[0] | ~r_last);
   assign w_tx       = r_grant[1] ? tx_byte[15:8] : tx_byte[7:0];
   assign w_in_wait  = (r_state == ST_WAIT_TRDY) || (r_state == ST_WAIT_RRDY);
   assign w_wait_hit = (r_wait == 10'(WAIT_LIMIT - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_read      = 1'b0;
      w_addr      = ADDR_RXDATA;
      w_wdata     = 16'h0000;
      w_abort     = 1'b0;
      tx_pop      = 2'b00;
      rx_valid    = 2'b00;
      done        = 2'b00;
      case (r_state)
         ST_IDLE: if (|req) w_state_nxt = ST_SSO_ON;
         ST_SSO_ON: begin
            w_addr  = ADDR_CONTROL;
            w_wdata = CTRL_SSO;
            w_start = ~w_bus_busy;
            if (w_bus_done) w_state_nxt = ST_WAIT_TRDY;
         end
         ST_WAIT_TRDY: begin
            if (spi_trdy) w_state_nxt = ST_WR_DATA;
            else if (w_wait_hit) begin
               w_abort     = 1'b1;
               w_state_nxt = ST_SSO_OFF;
            end
         end
         ST_WR_DATA: begin
            w_addr  = ADDR_TXDATA;
            w_wdata = {8'h00, w_tx};
            w_start = ~w_bus_busy;
            tx_pop  = r_grant & {2{w_bus_stb2}};
            if (w_bus_done) w_state_nxt = ST_WAIT_RRDY;
         end
         ST_WAIT_RRDY: begin
            if (spi_rrdy) w_state_nxt = ST_RD_DATA;
            else if (w_wait_hit) begin
               w_abort     = 1'b1;
               w_state_nxt = ST_SSO_OFF;
            end
         end
         ST_RD_DATA: begin
            w_addr   = ADDR_RXDATA;
            w_read   = 1'b1;
            w_start  = ~w_bus_busy;
            rx_valid = r_grant & {2{w_bus_done}};
            if (w_bus_done) w_state_nxt = (r_remaining > 5'd1) ? ST_WAIT_TRDY : ST_SSO_OFF;
         end
         ST_SSO_OFF: begin
            w_addr  = ADDR_CONTROL;
            w_wdata = CTRL_IDLE;
            w_start = ~w_bus_busy;
            if (w_bus_done) w_state_nxt = ST_DONE;
         end
         default: begin
            done        = r_grant;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_grant     <= 2'b00;
         r_remaining <= 5'd0;
         r_wait      <= 10'd0;
         r_err       <= 1'b0;
         r_last      <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_wait  <= w_in_wait ? r_wait + 10'd1 : 10'd0;
         if (r_state == ST_IDLE && |req) begin
            r_grant     <= w_pick1 ? 2'b10 : 2'b01;
            r_remaining <= burst_len(w_pick1 ? req_len[7:4] : req_len[3:0]);
         end
         if (r_state == ST_RD_DATA && w_bus_done) r_remaining <= r_remaining - 5'd1;
         if (w_abort) r_err <= 1'b1;
         if (r_state == ST_DONE) begin
            r_grant <= 2'b00;
            r_err   <= 1'b0;
            r_last  <= r_grant[1];
         end
      end
   end

   // The core's receive register carries the byte in its low half only.
   spi_bus_access u_bus (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_start       (w_start),
      .i_read        (w_read),
      .i_addr        (w_addr),
      .i_wdata       (w_wdata),
      .o_busy        (w_bus_busy),
      .o_stb2        (w_bus_stb2),
      .o_done        (w_bus_done),
      .o_rdata       (w_rdata),
      .o_spi_addr    (spi_addr),
      .o_spi_wdata   (spi_wdata),
      .o_spi_select  (spi_select),
      .o_spi_read_n  (spi_read_n),
      .o_spi_write_n (spi_write_n),
      .i_spi_rdata   (spi_rdata[7:0])
   );

   assign grant   = r_grant;
   assign err     = r_err;
   assign rx_byte = w_rdata;

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Directed bench for spi_burst_arbiter: echo-model SPI core, bus monitor, and
// hand-computed expectations for bursts, contention, 16-byte length, timeout and reset.
module tb_spi_burst_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [1:0]  req;
   logic [7:0]  req_len;
   logic [15:0] tx_byte;
   logic [1:0]  grant, tx_pop, rx_valid, done;
   logic [7:0]  rx_byte;
   logic        err;
   logic [2:0]  spi_addr;
   logic [15:0] spi_wdata;
   logic        spi_select, spi_read_n, spi_write_n;
   logic [15:0] spi_rdata;
   logic        spi_trdy, spi_rrdy;

   spi_burst_arbiter #(.WAIT_LIMIT(15)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req         (req),
      .req_len     (req_len),
      .tx_byte     (tx_byte),
      .grant       (grant),
      .tx_pop      (tx_pop),
      .rx_byte     (rx_byte),
      .rx_valid    (rx_valid),
      .done        (done),
      .err         (err),
      .spi_addr    (spi_addr),
      .spi_wdata   (spi_wdata),
      .spi_select  (spi_select),
      .spi_read_n  (spi_read_n),
      .spi_write_n (spi_write_n),
      .spi_rdata   (spi_rdata),
      .spi_trdy    (spi_trdy),
      .spi_rrdy    (spi_rrdy)
   );

   // ---------------- clock / reset ----------------
   always #10 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- SPI core echo model ----------------
   logic [7:0] r_echo = 8'h00;
   always @(posedge clk)
      if (spi_select && !spi_write_n && spi_addr == 3'd1) r_echo <= spi_wdata[7:0];
   assign spi_rdata = {8'h5A, r_echo};

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [19:0] exp_q[$];
   logic [19:0] acc_q[$];
   int          gap_q[$];
   logic [7:0]  rx0_q[$], rx1_q[$];
   logic [2:0]  done_q[$];
   logic [1:0]  grant_q[$];
   int pop0, pop1, rxv0, rxv1;
   int proto_err = 0;
   int sel_run = 0, idle_run = 0;
   logic [1:0] prev_grant = 2'b00;
   int idx0 = 0, idx1 = 0;
   logic [7:0] tx0_tbl [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic upd_tx();
      tx_byte = {8'h40 + idx1[7:0], tx0_tbl[idx0 % 4]};
   endtask

   task automatic clear_logs();
      acc_q.delete(); gap_q.delete(); rx0_q.delete(); rx1_q.delete();
      done_q.delete(); grant_q.delete(); exp_q.delete();
      pop0 = 0; pop1 = 0; rxv0 = 0; rxv1 = 0;
   endtask

   // ---------------- requester driver: advance TX byte on each pop ----------------
   always @(negedge clk) begin
      if (tx_pop[0]) idx0++;
      if (tx_pop[1]) idx1++;
      if (tx_pop != 2'b00) upd_tx();
   end

   // ---------------- bus / requester monitor ----------------
   always @(negedge clk) begin
      if (!reset_n) begin
         sel_run = 0; idle_run = 0; prev_grant = 2'b00;
      end else begin
         if (!spi_read_n && !spi_write_n) proto_err++;
         if (spi_select != (!spi_read_n || !spi_write_n)) proto_err++;
         if (spi_select) begin
            if (sel_run == 0) begin
               acc_q.push_back({~spi_read_n, spi_addr, spi_wdata});
               gap_q.push_back(idle_run);
            end
            sel_run++;
            idle_run = 0;
            if (sel_run > 2) proto_err++;
         end else begin
            if (sel_run == 1) proto_err++;
            sel_run = 0;
            idle_run++;
         end
         if (grant != 2'b00 && prev_grant == 2'b00) grant_q.push_back(grant);
         if (grant == 2'b11) proto_err++;
         prev_grant = grant;
         if (tx_pop[0]) pop0++;
         if (tx_pop[1]) pop1++;
         if (rx_valid[0]) begin rxv0++; rx0_q.push_back(rx_byte); end
         if (rx_valid[1]) begin rxv1++; rx1_q.push_back(rx_byte); end
         if (done != 2'b00) done_q.push_back({done, err});
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_done(input int budget, input string tag);
      int n0;
      int c;
      n0 = done_q.size();
      c  = 0;
      while (done_q.size() == n0 && c < budget) begin
         @(negedge clk); #1;
         c++;
      end
      check(tag, done_q.size() > n0, 1'b1);
   endtask

   task automatic cmp_acc(input string tag);
      check({tag, "_n"}, acc_q.size(), exp_q.size());
      foreach (exp_q[i])
         if (i < acc_q.size()) check($sformatf("%s_%0d", tag, i), acc_q[i], exp_q[i]);
   endtask

   task automatic check_rst(input string tag);
      check({tag, "_req"}, {grant, tx_pop, rx_valid, done, err}, 9'h000);
      check({tag, "_spi"}, {rx_byte, spi_addr, spi_wdata, spi_select, spi_read_n, spi_write_n},
            {8'h00, 3'd0, 16'h0000, 3'b011});
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk); #1;
   endtask

   // ---------------- directed tests ----------------
   logic [1:0] g_exp [3] = '{2'b01, 2'b10, 2'b01};

   initial begin
      req = 2'b00; req_len = 8'h00; tx_byte = 16'h0000; spi_trdy = 1'b1; spi_rrdy = 1'b1;
      #2 reset_n = 1'b0;
      #2 check_rst("reset");
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk); #1;

      // single 3-byte burst from requester 0
      clear_logs(); idx0 = 0; idx1 = 0; upd_tx();
      req_len = 8'h03; req = 2'b01;
      wait_done(400, "t1_done_seen");
      req = 2'b00;
      exp_q = {20'h30400, 20'h100A1, 20'h80000, 20'h100B2, 20'h80000,
               20'h100C3, 20'h80000, 20'h30000};
      cmp_acc("t1_acc");
      check("t1_pop0", pop0, 3);
      check("t1_rxv0", rxv0, 3);
      check("t1_rx0", (rx0_q.size() > 0) ? rx0_q[0] : 8'hxx, 8'hA1);
      check("t1_rx1", (rx0_q.size() > 1) ? rx0_q[1] : 8'hxx, 8'hB2);
      check("t1_rx2", (rx0_q.size() > 2) ? rx0_q[2] : 8'hxx, 8'hC3);
      check("t1_gap", (gap_q.size() > 1) ? gap_q[1] : -1, 3);
      check("t1_done", (done_q.size() > 0) ? done_q[0] : 3'bxxx, 3'b010);
      repeat (4) @(negedge clk); #1;

      // length 0 means 16 bytes, requester 1
      clear_logs(); idx0 = 0; idx1 = 0; upd_tx();
      req_len = 8'h00; req = 2'b10;
      wait_done(1000, "t3_done_seen");
      req = 2'b00;
      check("t3_pop1", pop1, 16);
      check("t3_rxv1", rxv1, 16);
      check("t3_pop0", pop0 + rxv0, 0);
      check("t3_nacc", acc_q.size(), 34);
      for (int i = 0; i < 16; i++)
         check($sformatf("t3_rx%0d", i), (rx1_q.size() > i) ? rx1_q[i] : 8'hxx, 8'h40 + i[7:0]);
      check("t3_done", (done_q.size() > 0) ? done_q[0] : 3'bxxx, 3'b100);

      // contention from reset: 0 first, then alternate
      do_reset();
      clear_logs(); idx0 = 0; idx1 = 0; upd_tx();
      req_len = 8'h11; req = 2'b11;
      wait_done(300, "t2_done0");
      wait_done(300, "t2_done1");
      wait_done(300, "t2_done2");
      req = 2'b00;
      repeat (20) @(negedge clk); #1;
      check("t2_ngrant", grant_q.size(), 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t2_grant%0d", i), (grant_q.size() > i) ? grant_q[i] : 2'bxx, g_exp[i]);
         check($sformatf("t2_done%0d", i), (done_q.size() > i) ? done_q[i] : 3'bxxx, {g_exp[i], 1'b0});
      end

      // RRDY stuck low: abort after 15 wait cycles
      clear_logs(); idx0 = 0; idx1 = 0; upd_tx();
      spi_rrdy = 1'b0; req_len = 8'h02; req = 2'b01;
      wait_done(400, "t4_done_seen");
      req = 2'b00; spi_rrdy = 1'b1;
      exp_q = {20'h30400, 20'h100A1, 20'h30000};
      cmp_acc("t4_acc");
      check("t4_gap", (gap_q.size() > 2) ? gap_q[2] : -1, 17);
      check("t4_pop0", pop0, 1);
      check("t4_rxv0", rxv0, 0);
      check("t4_done", (done_q.size() > 0) ? done_q[0] : 3'bxxx, 3'b011);
      repeat (4) @(negedge clk); #1;
      check("t4_err_clr", err, 1'b0);

      // reset after the first received byte, then a fresh burst
      clear_logs(); idx0 = 0; idx1 = 0; upd_tx();
      req_len = 8'h04; req = 2'b01;
      for (int c = 0; c < 200 && rxv0 < 1; c++) begin
         @(negedge clk); #1;
      end
      check("t5_byte1", rxv0, 1);
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1 check_rst("t5_rst");
      check("t5_nodone", done_q.size(), 0);
      req = 2'b00;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk); #1;
      check("t5_idle", {grant, spi_select}, 3'b000);
      clear_logs(); idx0 = 0; idx1 = 0; upd_tx();
      req_len = 8'h01; req = 2'b01;
      wait_done(200, "t5_done_seen");
      req = 2'b00;
      exp_q = {20'h30400, 20'h100A1, 20'h80000, 20'h30000};
      cmp_acc("t5_acc");
      check("t5_rx", (rx0_q.size() > 0) ? rx0_q[0] : 8'hxx, 8'hA1);
      check("t5_done", (done_q.size() > 0) ? done_q[0] : 3'bxxx, 3'b010);

      repeat (4) @(negedge clk); #1;
      check("proto", proto_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
